pc_gen_unit: RTL and testbench

Parametrised successor to the combinational PC+imm adder. Owns the architectural fetch PC register and computes sequential, branch, JAL and JALR targets internally. Handles stall, redirect priority and misaligned-target trapping via a 3-state FSM. Sits between the execute-stage branch resolution and the instruction-fetch port.

---
 rtl/pc_gen_unit.sv | 122 ++++++++++++
 tb/tb_pc_gen_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: sequential, branch, JAL and JALR targets with trap FSM.
// Optional RVC_EN adds is_compressed (+2 step, bit[0]-only misalign check).
module pc_gen_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned     IMM_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            trap_ack,
`ifdef RVC_EN
  input  logic            is_compressed,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            misalign,
  output logic [XLEN-1:0] bad_target
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ONE  = XLEN'(1);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] step;
  logic            redirect;
  logic            tgt_mis;

  assign br_tgt   = ex_pc + (imm << IMM_SHIFT);
  assign jalr_tgt = (rs1 + imm) & ~ONE;
  assign redirect = jalr | jal | br_taken;

  always_comb begin
    tgt = br_tgt;
    if (jalr) begin
      tgt = jalr_tgt;
    end
  end

`ifdef RVC_EN
  assign step    = is_compressed ? XLEN'(2) : FOUR;
  assign tgt_mis = tgt[0];
`else
  assign step    = FOUR;
  assign tgt_mis = tgt[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      bad_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    mis_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect && tgt_mis) begin
          pc_d    = TRAP_VEC;
          bad_d   = tgt;
          mis_d   = 1'b1;
          state_d = TRAP;
        end else if (redirect) begin
          // redirect wins over stall; upstream flushes
          pc_d = tgt;
        end else if (!stall) begin
          pc_d = pc_q + step;
        end
      end
      TRAP: begin
        if (trap_ack) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + FOUR;
  assign pc_valid   = (state_q == RUN);
  assign misalign   = mis_q;
  assign bad_target = bad_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: per-cycle reference model plus directed literals.
// Targets the default build (RVC_EN undefined).
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_taken, jal, jalr, trap_ack;
  logic [31:0] ex_pc, imm, rs1;
  logic [31:0] pc, pc_plus4, bad_target;
  logic        pc_valid, misalign;

  int n_chk  = 0;
  int n_pass = 0;

  pc_gen_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .jal        (jal),
    .jalr       (jalr),
    .ex_pc      (ex_pc),
    .imm        (imm),
    .rs1        (rs1),
    .trap_ack   (trap_ack),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .pc_valid   (pc_valid),
    .misalign   (misalign),
    .bad_target (bad_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference: "phase" 0 = booting, 1 = fetching, 2 = waiting on trap handler
  int          m_phase;
  logic [31:0] m_pc, m_bad, t;
  logic        m_mis;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_pc    = 32'h0;
      m_bad   = 32'h0;
      m_mis   = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 2) begin
        if (trap_ack) m_phase = 1;
      end else if (jalr || jal || br_taken) begin
        if (jalr) t = (rs1 + imm) & 32'hFFFF_FFFE;
        else      t = ex_pc + imm * 2;
        if (t % 4 != 0) begin
          m_pc    = 32'h100;
          m_bad   = t;
          m_mis   = 1'b1;
          m_phase = 2;
        end else begin
          m_pc = t;
        end
      end else if (!stall) begin
        m_pc = m_pc + 4;
      end
    end
    #1;
    chk("cyc_pc", pc, m_pc);
    chk("cyc_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("cyc_valid", {31'b0, pc_valid}, {31'b0, m_phase == 1});
    chk("cyc_misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("cyc_bad_target", bad_target, m_bad);
  end

  task automatic idle();
    stall = 0; br_taken = 0; jal = 0; jalr = 0; trap_ack = 0;
    ex_pc = 0; imm = 0; rs1 = 0;
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    nxt(1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_bad", bad_target, 32'h0);
    rst = 1'b0;
    nxt(1);
    chk("boot_pc", pc, 32'h0);
    chk("run_valid", {31'b0, pc_valid}, 32'h1);
    nxt(1);
    chk("seq_4", pc, 32'h4);
    nxt(1);
    chk("seq_8", pc, 32'h8);

    br_taken = 1; ex_pc = 32'h10; imm = 32'h3;
    nxt(1);
    idle();
    chk("trap_pc", pc, 32'h100);
    chk("trap_pulse", {31'b0, misalign}, 32'h1);
    chk("trap_bad", bad_target, 32'h16);
    chk("trap_valid", {31'b0, pc_valid}, 32'h0);
    nxt(1);
    chk("trap_pulse_end", {31'b0, misalign}, 32'h0);
    jal = 1; stall = 1; ex_pc = 32'h40;
    nxt(1);
    idle();
    chk("trap_ignores", pc, 32'h100);
    trap_ack = 1;
    nxt(1);
    trap_ack = 0;
    chk("ack_pc", pc, 32'h100);
    chk("ack_valid", {31'b0, pc_valid}, 32'h1);
    nxt(1);
    chk("after_ack", pc, 32'h104);

    trap_ack = 1;
    nxt(1);
    chk("ack_in_run", pc, 32'h108);
    idle();
    jal = 1; stall = 1; ex_pc = 32'h20; imm = 32'h2;
    nxt(1);
    idle();
    stall = 1;
    chk("jal_beats_stall", pc, 32'h24);
    nxt(3);
    chk("stall_hold", pc, 32'h24);
    idle();

    jalr = 1; rs1 = 32'h1001; imm = 32'h10;
    br_taken = 1; ex_pc = 32'h0;
    nxt(1);
    idle();
    chk("jalr_prio", pc, 32'h1010);

    jal = 1; ex_pc = 32'hFFFF_FFF0; imm = 32'h6;
    nxt(1);
    idle();
    chk("near_top", pc, 32'hFFFF_FFFC);
    nxt(1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_nomis", {31'b0, misalign}, 32'h0);

    jal = 1; ex_pc = 32'h40; imm = 32'hFFFF_FFFC;
    nxt(1);
    idle();
    chk("jal_neg", pc, 32'h38);

    jalr = 1; rs1 = 32'h2002; imm = 32'h0;
    nxt(1);
    idle();
    chk("jalr_trap_bad", bad_target, 32'h2002);
    nxt(1);
    rst = 1'b1;
    nxt(1);
    rst = 1'b0;
    chk("rst_in_trap_pc", pc, 32'h0);
    chk("rst_in_trap_bad", bad_target, 32'h0);
    chk("rst_in_trap_boot", {31'b0, pc_valid}, 32'h0);
    nxt(1);
    chk("rst_then_run", {31'b0, pc_valid}, 32'h1);
    stall = 1;
    nxt(2);
    rst = 1'b1;
    nxt(1);
    rst = 1'b0;
    idle();
    chk("rst_in_stall", {31'b0, pc_valid}, 32'h0);
    nxt(2);
    chk("rst_in_stall_seq", pc, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
